serial_tx_4: RTL and testbench

Parallel-in, serial-out transmitter for 4-bit words. It is the sending end of the 4-bit storage path: it accepts a word over a valid/ready handshake, latches it, and drives a framed serial line (start, data LSB first, optional even parity, stop). It sits between a 4-bit datapath register and a single-wire serial link.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_tx_4_bit_timer.sv | 32 +++
 rtl/serial_tx_4.sv | 127 ++++++++++++
 tb/tb_serial_tx_4.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the 4-bit serial transmit path.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 4;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_tx_4_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last cycle
// of each bit period. Held at zero while clear is high so that the first
// period after release is a full one.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  output logic bit_end
);

  // A one-cycle bit still needs a one-bit counter that simply stays at 0.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;

  // Free-running 0..CLKS_PER_BIT-1 counter, wrapping at each bit boundary.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign bit_end = (cnt_reg == LAST);

endmodule

// File: rtl/serial_tx_4.sv
// Parallel-in, serial-out transmitter for 4-bit words.
// Frame: start (0), d0..d3 LSB first, optional even parity, stop (1).
// All outputs are registered; o_tx changes in the cycle after the edge
// that decides the new bit.
module serial_tx_4
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [3:0] i_data,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [1:0] LAST_BIT = 2'(DATA_BITS - 1);

  tx_state_t            state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           bit_cnt_reg;
  logic                 parity_reg;
  logic                 tx_reg;
  logic                 ready_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 bit_end;

  // The timer is parked at zero in IDLE so the start bit gets a full period
  // counted from the accepting edge.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (i_clk),
    .srst    (i_rst),
    .clear   (state_reg == IDLE),
    .bit_end (bit_end)
  );

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= LINE_IDLE;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tx_reg    <= LINE_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          if (i_valid) begin
            // Parity is taken from the word as accepted, before shifting.
            shift_reg  <= i_data;
            parity_reg <= even_parity(i_data);
            state_reg  <= START;
            tx_reg     <= START_BIT;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_reg   <= DATA;
            bit_cnt_reg <= '0;
            tx_reg      <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_reg == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state_reg <= PARITY;
                tx_reg    <= parity_reg;
              end else begin
                state_reg <= STOP;
                tx_reg    <= STOP_BIT;
              end
            end else begin
              // Next bit is shift_reg[1]; drive it as the register shifts.
              shift_reg   <= {1'b0, shift_reg[DATA_BITS-1:1]};
              bit_cnt_reg <= bit_cnt_reg + 2'd1;
              tx_reg      <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_reg <= STOP;
            tx_reg    <= STOP_BIT;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_reg <= IDLE;
            tx_reg    <= LINE_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= LINE_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx    = tx_reg;
  assign o_ready = ready_reg;
  assign o_busy  = busy_reg;
  assign o_done  = done_reg;

endmodule

// File: tb/tb_serial_tx_4.sv
// Bench for serial_tx_4: one instance with parity and 4 clocks per bit,
// one without parity and 1 clock per bit.
module tb_serial_tx_4;

  logic       clk = 1'b0;
  logic       rst0, valid0, ready0, tx0, busy0, done0;
  logic [3:0] data0;
  logic       rst1, valid1, ready1, tx1, busy1, done1;
  logic [3:0] data1;

  int total = 0;
  int bad   = 0;

  logic exp_q[$];

  typedef struct {
    logic [3:0] data;
    logic       par;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  serial_tx_4 #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_valid(valid0), .i_data(data0),
    .o_ready(ready0), .o_tx(tx0), .o_busy(busy0), .o_done(done0)
  );

  serial_tx_4 #(.CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_valid(valid1), .i_data(data1),
    .o_ready(ready1), .o_tx(tx1), .o_busy(busy1), .o_done(done1)
  );

  function automatic logic tx_of(input int w);
    return (w == 0) ? tx0 : tx1;
  endfunction
  function automatic logic ready_of(input int w);
    return (w == 0) ? ready0 : ready1;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? busy0 : busy1;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 0) ? done0 : done1;
  endfunction

  task automatic chk(input string nm, input int w, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%b want=%b", nm, w, $time, act, exp);
    end
  endtask

  // Expected line values, one entry per serial bit, in transmit order.
  task automatic push_frame(input int w, input logic [3:0] d, input logic par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
    if (w == 0) exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  // Called just after the accepting edge: checks cycles 1..N, then N+1.
  task automatic check_frame(input int w);
    int   cpb;
    int   nb;
    logic e;
    cpb = (w == 0) ? 4 : 1;
    nb  = (w == 0) ? 7 : 6;
    for (int b = 0; b < nb; b++) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty dut%0d got=0 want=1", w);
        e = 1'b1;
      end else begin
        e = exp_q.pop_front();
      end
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        chk("frame_tx", w, tx_of(w), e);
        chk("frame_busy", w, busy_of(w), 1'b1);
        chk("frame_ready", w, ready_of(w), 1'b0);
        chk("frame_done", w, done_of(w), 1'b0);
      end
    end
    @(negedge clk);
    chk("done_pulse", w, done_of(w), 1'b1);
    chk("done_tx", w, tx_of(w), 1'b1);
    chk("done_ready", w, ready_of(w), 1'b1);
    chk("done_busy", w, busy_of(w), 1'b0);
  endtask

  task automatic drive(input int w, input logic v, input logic [3:0] d);
    if (w == 0) begin
      valid0 = v;
      data0  = d;
    end else begin
      valid1 = v;
      data1  = d;
    end
  endtask

  task automatic send(input int w, input logic [3:0] d, input logic par);
    @(posedge clk);
    #1;
    drive(w, 1'b1, d);
    push_frame(w, d, par);
    @(negedge clk);
    chk("ready_before", w, ready_of(w), 1'b1);
    @(posedge clk);
    #1;
    drive(w, 1'b0, 4'($urandom_range(0, 15)));
    check_frame(w);
    $display("frame dut%0d data=%b par=%b", w, d, par);
  endtask

  task automatic check_idle(input int w, input int cycles, input string nm);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk({nm, "_tx"}, w, tx_of(w), 1'b1);
      chk({nm, "_ready"}, w, ready_of(w), 1'b1);
      chk({nm, "_busy"}, w, busy_of(w), 1'b0);
      chk({nm, "_done"}, w, done_of(w), 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b1011, 1'b1};
    tbl[1] = '{4'b0000, 1'b0};
    tbl[2] = '{4'b1111, 1'b0};
    tbl[3] = '{4'b0111, 1'b1};
    tbl[4] = '{4'b1000, 1'b1};
    tbl[5] = '{4'b1010, 1'b0};
    tbl[6] = '{4'b0101, 1'b0};
    tbl[7] = '{4'b0110, 1'b0};

    // Reset held 3 cycles with valid high: stays idle, nothing accepted.
    rst0 = 1'b1; rst1 = 1'b1;
    valid0 = 1'b1; valid1 = 1'b1;
    data0 = 4'hC; data1 = 4'h3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        chk("rst_tx", w, tx_of(w), 1'b1);
        chk("rst_ready", w, ready_of(w), 1'b1);
        chk("rst_busy", w, busy_of(w), 1'b0);
        chk("rst_done", w, done_of(w), 1'b0);
      end
    end
    @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    check_idle(0, 2, "post_rst");
    $display("reset check done");

    // Table-driven frames on both instances.
    for (int i = 0; i < 8; i++) send(0, tbl[i].data, tbl[i].par);
    for (int i = 0; i < 8; i++) send(1, tbl[i].data, tbl[i].par);

    // Back-to-back: valid held high, second word taken in the done cycle.
    @(posedge clk);
    #1;
    drive(0, 1'b1, 4'hA);
    push_frame(0, 4'hA, 1'b0);
    push_frame(0, 4'h5, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 4'h5);
    check_frame(0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 4'h0);
    check_frame(0);
    $display("frame dut0 back-to-back A then 5");

    // Busy ignore: a 4'hF offered mid-frame must not disturb or follow.
    @(posedge clk);
    #1;
    drive(0, 1'b1, 4'h0);
    push_frame(0, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 4'h0);
    fork
      check_frame(0);
      begin
        repeat (9) @(posedge clk);
        #1;
        drive(0, 1'b1, 4'hF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 4'h0);
      end
    join
    check_idle(0, 6, "ignored_word");
    $display("frame dut0 data=0000 with ignored F");

    // Mid-frame reset in cycle 9, then a clean frame.
    @(posedge clk);
    #1;
    drive(0, 1'b1, 4'h0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 4'h0);
    repeat (8) @(posedge clk);
    #1;
    rst0 = 1'b1;
    @(negedge clk);
    chk("pre_abort_tx", 0, tx0, 1'b0);
    chk("pre_abort_busy", 0, busy0, 1'b1);
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    check_idle(0, 36, "abort");
    $display("frame dut0 aborted by reset");
    send(0, 4'b1011, 1'b1);

    // Same abort on the no-parity instance, during its data bits.
    @(posedge clk);
    #1;
    drive(1, 1'b1, 4'h0);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    check_idle(1, 10, "abort1");
    $display("frame dut1 aborted by reset");
    send(1, 4'b1001, 1'b0);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
